// File: rtl/dmr_retry_compare.sv
// rtl/dmr_retry_compare.sv - DMR join-and-compare stage feeding the in-order retry end
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   a_data_i/a_id_i/a_valid_i/a_ready_o   lane A handshake (payload + retry ID)
//   b_data_i/b_id_i/b_valid_i/b_ready_o   lane B handshake (payload + retry ID)
//   data_o/id_o/needs_retry_o/valid_o/ready_i   registered output item
//   fault_o                  one-cycle pulse after a faulty item is loaded
module dmr_retry_compare #(
  parameter type         DataType      = logic,
  parameter int unsigned IDSize        = 4,
  parameter int unsigned TimeoutCycles = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  DataType           a_data_i,
  input  logic [IDSize-1:0] a_id_i,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  DataType           b_data_i,
  input  logic [IDSize-1:0] b_id_i,
  input  logic              b_valid_i,
  output logic              b_ready_o,
  output DataType           data_o,
  output logic [IDSize-1:0] id_o,
  output logic              needs_retry_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              fault_o
);

  // Keep the counter at least one bit wide so TimeoutCycles = 0 still elaborates.
  localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntMax = (TimeoutCycles > 0) ? CntW'(TimeoutCycles - 1) : '0;
  localparam bit TimeoutEn = (TimeoutCycles > 0);

  DataType           data_q;
  logic [IDSize-1:0] id_q;
  logic              retry_q;
  logic              valid_q;
  logic              fault_q;
  logic [CntW-1:0]   cnt_q;

  logic              out_free;
  logic              both_valid;
  logic              lone_a;
  logic              lone_b;
  logic              timed_out;
  logic              join_pop;
  logic              to_pop_a;
  logic              to_pop_b;
  logic              load;
  DataType           data_d;
  logic [IDSize-1:0] id_d;
  logic              retry_d;

  assign out_free   = ~valid_q | ready_i;
  assign both_valid = a_valid_i & b_valid_i;
  assign lone_a     = a_valid_i & ~b_valid_i;
  assign lone_b     = b_valid_i & ~a_valid_i;
  assign timed_out  = TimeoutEn && (cnt_q == CntMax);

  // Join has priority: the timeout path only ever fires for a lone lane.
  assign join_pop = both_valid & out_free;
  assign to_pop_a = lone_a & timed_out & out_free;
  assign to_pop_b = lone_b & timed_out & out_free;
  assign load     = rst_ni & (join_pop | to_pop_a | to_pop_b);

  assign a_ready_o = rst_ni & (join_pop | to_pop_a);
  assign b_ready_o = rst_ni & (join_pop | to_pop_b);

  // A timed-out lone lane is always a fault; a join is a fault on any disagreement.
  always_comb begin
    data_d  = a_data_i;
    id_d    = a_id_i;
    retry_d = 1'b1;
    if (join_pop) begin
      retry_d = (a_data_i != b_data_i) | (a_id_i != b_id_i);
    end else if (to_pop_b) begin
      data_d = b_data_i;
      id_d   = b_id_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q  <= '0;
      id_q    <= '0;
      retry_q <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      fault_q <= load & retry_d;
      if (load) begin
        data_q  <= data_d;
        id_q    <= id_d;
        retry_q <= retry_d;
        valid_q <= 1'b1;
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  // Wait counter only ages while a single lane is stuck without a pop.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (!TimeoutEn || load || !(lone_a | lone_b)) begin
      cnt_q <= '0;
    end else if (cnt_q != CntMax) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign data_o        = data_q;
  assign id_o          = id_q;
  assign needs_retry_o = retry_q;
  assign valid_o       = valid_q;
  assign fault_o       = fault_q;

endmodule

// File: tb/tb_dmr_retry_compare.sv
// tb/tb_dmr_retry_compare.sv - self-checking bench for dmr_retry_compare
module tb_dmr_retry_compare;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic [7:0] a_data = '0, b_data = '0;
  logic [3:0] a_id = '0, b_id = '0;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic       a_ready, b_ready;
  logic [7:0] data_o;
  logic [3:0] id_o;
  logic       needs_retry, valid_o, fault_o;
  logic       ready_i = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  dmr_retry_compare #(
    .DataType     (logic [7:0]),
    .IDSize       (4),
    .TimeoutCycles(TO)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .a_data_i     (a_data),
    .a_id_i       (a_id),
    .a_valid_i    (a_valid),
    .a_ready_o    (a_ready),
    .b_data_i     (b_data),
    .b_id_i       (b_id),
    .b_valid_i    (b_valid),
    .b_ready_o    (b_ready),
    .data_o       (data_o),
    .id_o         (id_o),
    .needs_retry_o(needs_retry),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .fault_o      (fault_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: an optional held item plus the age of a lone waiting lane.
  bit         model_on = 0;
  bit         m_valid = 0, m_retry = 0, m_fault = 0;
  logic [7:0] m_data = '0;
  logic [3:0] m_id = '0;
  int         m_wait = 0;
  bit         n_valid, n_retry, n_fault;
  logic [7:0] n_data;
  logic [3:0] n_id;
  int         n_wait;
  bit         e_pa, e_pb, free;

  always @(negedge clk) if (model_on) begin
    free = !m_valid || ready_i;
    e_pa = 0;
    e_pb = 0;
    if (rst_ni) begin
      if (a_valid && b_valid) begin
        e_pa = free;
        e_pb = free;
      end else if (a_valid != b_valid) begin
        if (m_wait >= TO - 1 && free) begin
          e_pa = a_valid;
          e_pb = b_valid;
        end
      end
    end
    chk("cmp a_ready", a_ready, e_pa);
    chk("cmp b_ready", b_ready, e_pb);
    chk("cmp valid_o", valid_o, m_valid);
    chk("cmp fault_o", fault_o, m_fault);
    if (m_valid) begin
      chk("cmp data_o", data_o, m_data);
      chk("cmp id_o", id_o, m_id);
      chk("cmp needs_retry", needs_retry, m_retry);
    end
    n_valid = m_valid && !ready_i;
    n_data  = m_data;
    n_id    = m_id;
    n_retry = m_retry;
    n_fault = 0;
    n_wait  = 0;
    if (!rst_ni) begin
      n_valid = 0;
      n_data  = '0;
      n_id    = '0;
      n_retry = 0;
    end else if (e_pa || e_pb) begin
      n_valid = 1;
      n_data  = e_pb && !e_pa ? b_data : a_data;
      n_id    = e_pb && !e_pa ? b_id : a_id;
      n_retry = (e_pa && e_pb) ? (a_data != b_data || a_id != b_id) : 1'b1;
      n_fault = n_retry;
    end else if (a_valid != b_valid) begin
      n_wait = (m_wait + 1 > TO - 1) ? TO - 1 : m_wait + 1;
    end
  end

  always @(posedge clk) if (model_on) begin
    m_valid = n_valid;
    m_data  = n_data;
    m_id    = n_id;
    m_retry = n_retry;
    m_fault = n_fault;
    m_wait  = n_wait;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input bit v, input logic [7:0] d, input logic [3:0] id);
    a_valid = v; a_data = d; a_id = id;
  endtask

  task automatic set_b(input bit v, input logic [7:0] d, input logic [3:0] id);
    b_valid = v; b_data = d; b_id = id;
  endtask

  initial begin
    rst_ni = 0;
    cyc();
    cyc();
    rst_ni = 1;
    model_on = 1;
    chk("reset valid_o", valid_o, 0);
    chk("reset data_o", data_o, 0);
    chk("reset id_o", id_o, 0);
    chk("reset needs_retry", needs_retry, 0);
    chk("reset fault_o", fault_o, 0);

    // matching pair
    set_a(1, 8'h5A, 4'd3); set_b(1, 8'h5A, 4'd3);
    #1;
    chk("match a_ready", a_ready, 1);
    chk("match b_ready", b_ready, 1);
    cyc();
    set_a(0, 0, 0); set_b(0, 0, 0);
    chk("match valid_o", valid_o, 1);
    chk("match data_o", data_o, 8'h5A);
    chk("match id_o", id_o, 3);
    chk("match needs_retry", needs_retry, 0);
    chk("match fault_o", fault_o, 0);

    // data mismatch
    set_a(1, 8'h11, 4'd7); set_b(1, 8'h13, 4'd7);
    cyc();
    set_a(0, 0, 0); set_b(0, 0, 0);
    chk("dmis id_o", id_o, 7);
    chk("dmis needs_retry", needs_retry, 1);
    chk("dmis fault_o", fault_o, 1);
    cyc();
    chk("dmis fault_o drop", fault_o, 0);
    chk("dmis drained", valid_o, 0);

    // ID mismatch
    set_a(1, 8'hAA, 4'd2); set_b(1, 8'hAA, 4'd4);
    cyc();
    set_a(0, 0, 0); set_b(0, 0, 0);
    chk("imis needs_retry", needs_retry, 1);
    chk("imis id_o", id_o, 2);
    chk("imis data_o", data_o, 8'hAA);
    cyc();

    // lone lane A times out in cycle TO-1
    set_a(1, 8'h22, 4'd9);
    for (int i = 0; i < TO; i++) begin
      #1;
      chk($sformatf("to a_ready c%0d", i), a_ready, (i == TO - 1));
      chk($sformatf("to b_ready c%0d", i), b_ready, 0);
      cyc();
    end
    set_a(0, 0, 0);
    chk("to valid_o", valid_o, 1);
    chk("to data_o", data_o, 8'h22);
    chk("to id_o", id_o, 9);
    chk("to needs_retry", needs_retry, 1);
    chk("to fault_o", fault_o, 1);
    cyc();

    // partner arrives in cycle 2: normal join
    set_a(1, 8'h22, 4'd9);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("late a_ready c%0d", i), a_ready, 0);
      cyc();
    end
    set_b(1, 8'h22, 4'd9);
    #1;
    chk("late a_ready join", a_ready, 1);
    chk("late b_ready join", b_ready, 1);
    cyc();
    set_a(0, 0, 0); set_b(0, 0, 0);
    chk("late valid_o", valid_o, 1);
    chk("late needs_retry", needs_retry, 0);
    cyc();

    // backpressure with a second pair waiting
    set_a(1, 8'h31, 4'd1); set_b(1, 8'h31, 4'd1);
    cyc();
    ready_i = 0;
    set_a(1, 8'h42, 4'd5); set_b(1, 8'h42, 4'd5);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp a_ready", a_ready, 0);
      chk("bp b_ready", b_ready, 0);
      chk("bp data_o", data_o, 8'h31);
      chk("bp id_o", id_o, 1);
      chk("bp valid_o", valid_o, 1);
      cyc();
    end
    ready_i = 1;
    #1;
    chk("bp release a_ready", a_ready, 1);
    chk("bp release b_ready", b_ready, 1);
    cyc();
    set_a(0, 0, 0); set_b(0, 0, 0);
    chk("bp second data_o", data_o, 8'h42);
    chk("bp second id_o", id_o, 5);
    chk("bp second valid_o", valid_o, 1);

    // reset while an item is held and a lone lane is waiting
    ready_i = 0;
    set_a(1, 8'h77, 4'd6);
    cyc();
    cyc();
    rst_ni = 0;
    #1;
    chk("rst a_ready forced", a_ready, 0);
    cyc();
    rst_ni = 1;
    chk("rst valid_o", valid_o, 0);
    chk("rst fault_o", fault_o, 0);
    chk("rst data_o", data_o, 0);
    ready_i = 1;
    for (int i = 0; i < TO; i++) begin
      #1;
      chk($sformatf("rst to a_ready c%0d", i), a_ready, (i == TO - 1));
      cyc();
    end
    set_a(0, 0, 0);
    chk("rst to id_o", id_o, 6);

    // lone lane B with the output blocked at timeout: pops on the first free cycle
    ready_i = 0;
    set_b(1, 8'h99, 4'd12);
    for (int i = 0; i < TO + 2; i++) cyc();
    ready_i = 1;
    #1;
    chk("blk b_ready", b_ready, 1);
    chk("blk a_ready", a_ready, 0);
    cyc();
    set_b(0, 0, 0);
    chk("blk id_o", id_o, 12);
    chk("blk data_o", data_o, 8'h99);
    cyc();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
